// File: rtl/mmio_pkg.sv
// Shared types, defaults and width helper for the MMIO bridge.
package mmio_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MEM,
    REG_IO,
    REG_BAD
  } region_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  // Ceiling log2, never below 1 so that derived vectors keep a legal width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned CH_SPAN_DEFAULT = 16;
  localparam int unsigned OFF_W_DEFAULT   = clog2(CH_SPAN_DEFAULT);

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decode: memory, IO channel/offset, or unmapped.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned CH_SPAN = 16,
  localparam int unsigned CH_W   = clog2(NUM_CH),
  localparam int unsigned OFF_W  = clog2(CH_SPAN)
) (
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_addr,
  output region_e           region,
  output logic [CH_W-1:0]   ch_idx,
  output logic [OFF_W-1:0]  offset
);

  // One extra bit keeps the window end from wrapping at the top of the map.
  localparam logic [DATA_W:0] BASE_X = (DATA_W+1)'(IO_BASE);
  localparam logic [DATA_W:0] SPAN_X = (DATA_W+1)'(NUM_CH * CH_SPAN);

  logic [DATA_W:0] addr_x;
  logic [DATA_W:0] rel_x;

  always_comb begin
    addr_x = {1'b0, cpu_addr};
    rel_x  = addr_x - BASE_X;
    ch_idx = rel_x[OFF_W +: CH_W];
    offset = rel_x[OFF_W-1:0];
    if (!cpu_rd && !cpu_wr) begin
      region = REG_NONE;
    end else if (cpu_rd && cpu_wr) begin
      region = REG_BAD;
    end else if (addr_x < BASE_X) begin
      region = REG_MEM;
    end else if (rel_x < SPAN_X) begin
      region = REG_IO;
    end else begin
      region = REG_BAD;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU load/store bridge: zero-latency memory path plus stalled, timed-out
// accesses to NUM_CH peripheral channels.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IO_W    = 16,
  parameter int unsigned NUM_CH  = 4,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned CH_SPAN = 16,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned OFF_W  = clog2(CH_SPAN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [DATA_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic                   cpu_err,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [NUM_CH-1:0]      io_sel,
  output logic                   io_re,
  output logic                   io_we,
  output logic [OFF_W-1:0]       io_addr,
  output logic [IO_W-1:0]        io_wdata,
  input  logic [NUM_CH*IO_W-1:0] io_rdata,
  input  logic [NUM_CH-1:0]      io_ready
);

  localparam int unsigned CH_W  = clog2(NUM_CH);
  localparam int unsigned CNT_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  region_e          region;
  logic [CH_W-1:0]  dec_ch;
  logic [OFF_W-1:0] dec_off;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             wr_q, wr_d;
  logic [IO_W-1:0]  wdata_q, wdata_d;
  logic [IO_W-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sel_ready;
  logic [IO_W-1:0]  sel_data;

  mmio_addr_decode #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .IO_BASE(IO_BASE),
    .CH_SPAN(CH_SPAN)
  ) u_decode (
    .cpu_rd  (cpu_rd),
    .cpu_wr  (cpu_wr),
    .cpu_addr(cpu_addr),
    .region  (region),
    .ch_idx  (dec_ch),
    .offset  (dec_off)
  );

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign io_addr   = off_q;
  assign io_wdata  = wdata_q;

  // Only the latched channel's ready/data are visible to the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_ready = io_ready[c];
        sel_data  = io_rdata[c*IO_W +: IO_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    off_d     = off_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    io_sel    = '0;
    io_re     = 1'b0;
    io_we     = 1'b0;
    cpu_stall = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = '0;
    unique case (state_q)
      S_IDLE: begin
        cpu_rdata = mem_rdata;
        if (region == REG_MEM) begin
          mem_re = cpu_rd;
          mem_we = cpu_wr;
        end else if (region != REG_NONE) begin
          cpu_stall = 1'b1;
          ch_d      = dec_ch;
          off_d     = dec_off;
          wr_d      = cpu_wr;
          wdata_d   = cpu_wdata[IO_W-1:0];
          rdata_d   = '0;
          cnt_d     = '0;
          if (region == REG_IO) begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        cpu_stall = 1'b1;
        io_sel    = NUM_CH'(1) << ch_q;
        io_re     = ~wr_q;
        io_we     = wr_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (sel_ready) begin
          rdata_d = sel_data;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cpu_rdata = DATA_W'(rdata_q);
        cpu_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      off_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: directed transfers push expectations,
// a negedge monitor pops one per completed CPU access.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata = 32'h1234_5678;
  logic [3:0]  io_sel;
  logic        io_re, io_we;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata;
  logic [63:0] io_rdata = {16'h3333, 16'h2222, 16'hABCD, 16'h1111};
  logic [3:0]  io_ready = '0;

  always #5 clk = ~clk;

  mmio_bridge #(
    .DATA_W (32),
    .IO_W   (16),
    .NUM_CH (4),
    .IO_BASE(32'hFFFF_FC00),
    .CH_SPAN(16),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_err  (cpu_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .io_sel   (io_sel),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_ready (io_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    logic [3:0]  sel;
    int          re_cyc;
    int          we_cyc;
    logic [15:0] wd;
    logic [3:0]  addr;
    logic [1:0]  mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] rdata, input logic err,
                              input int stalls, input logic [3:0] sel, input int re_cyc,
                              input int we_cyc, input logic [15:0] wd, input logic [3:0] addr,
                              input logic [1:0] mem);
    exp_t e;
    e.name = name; e.rdata = rdata; e.err = err; e.stalls = stalls; e.sel = sel;
    e.re_cyc = re_cyc; e.we_cyc = we_cyc; e.wd = wd; e.addr = addr; e.mem = mem;
    return e;
  endfunction

  // Monitor: accumulates strobe activity while stalled, checks at completion.
  logic        prev_stall = 1'b0;
  int          m_stalls = 0, m_re = 0, m_we = 0;
  logic [3:0]  m_sel = '0;
  logic [15:0] m_wd = '0;
  logic [3:0]  m_addr = '0;
  logic [1:0]  m_mem = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      m_stalls = 0; m_re = 0; m_we = 0; m_sel = '0; m_wd = '0; m_addr = '0; m_mem = '0;
    end else begin
      m_sel = m_sel | io_sel;
      m_mem = m_mem | {mem_re, mem_we};
      if (io_re) m_re++;
      if (io_we) m_we++;
      if (io_re || io_we) begin
        m_wd = io_wdata;
        m_addr = io_addr;
      end
      if (cpu_stall) begin
        m_stalls++;
        prev_stall = 1'b1;
      end else if (cpu_rd || cpu_wr || prev_stall) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'(cpu_err), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, ".rdata"}, cpu_rdata, e.rdata);
          chk({e.name, ".err"}, 32'(cpu_err), 32'(e.err));
          chk({e.name, ".stalls"}, 32'(m_stalls), 32'(e.stalls));
          chk({e.name, ".io_sel"}, 32'(m_sel), 32'(e.sel));
          chk({e.name, ".re_cyc"}, 32'(m_re), 32'(e.re_cyc));
          chk({e.name, ".we_cyc"}, 32'(m_we), 32'(e.we_cyc));
          chk({e.name, ".io_wdata"}, 32'(m_wd), 32'(e.wd));
          chk({e.name, ".io_addr"}, 32'(m_addr), 32'(e.addr));
          chk({e.name, ".mem_strb"}, 32'(m_mem), 32'(e.mem));
        end
        prev_stall = 1'b0;
        m_stalls = 0; m_re = 0; m_we = 0; m_sel = '0; m_wd = '0; m_addr = '0; m_mem = '0;
      end
    end
  end

  // Drives one CPU access and acts as the peripheral: ready mask in cycle
  // rdy_at (first ACCESS cycle = 1), noise mask otherwise, optional early drop.
  task automatic xfer(input exp_t e, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int rdy_at, input logic [3:0] rdy_mask,
                      input logic [3:0] noise, input int drop_at);
    logic done;
    done = 1'b0;
    exp_q.push_back(e);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      io_ready = (i == rdy_at) ? rdy_mask : noise;
      if (i == drop_at) begin
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
      end
    end
    chk({e.name, ".completed"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; io_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst.io_sel", 32'(io_sel), 32'd0);
    chk("rst.io_strb", 32'({io_re, io_we}), 32'd0);
    chk("rst.cpu_err", 32'(cpu_err), 32'd0);
    chk("rst.cpu_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(mk("mem_load", 32'h1234_5678, 0, 0, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b10),
         1, 0, 32'h0000_0010, 32'h0, 0, 4'h0, 4'h0, 0);
    xfer(mk("mem_store", 32'h1234_5678, 0, 0, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b01),
         0, 1, 32'h0000_0200, 32'hCAFE_F00D, 0, 4'h0, 4'h0, 0);
    xfer(mk("io_load_ch1", 32'h0000_ABCD, 0, 2, 4'b0010, 1, 0, 16'h7777, 4'h0, 2'b00),
         1, 0, 32'hFFFF_FC10, 32'h5555_7777, 1, 4'b0010, 4'h0, 0);
    xfer(mk("io_store_ch0", 32'h0000_1111, 0, 4, 4'b0001, 0, 3, 16'hBEEF, 4'h0, 2'b00),
         0, 1, 32'hFFFF_FC00, 32'hDEAD_BEEF, 3, 4'b0001, 4'h0, 0);
    xfer(mk("io_load_ch3_off", 32'h0000_3333, 0, 3, 4'b1000, 2, 0, 16'h0042, 4'hA, 2'b00),
         1, 0, 32'hFFFF_FC3A, 32'h0000_0042, 2, 4'b1000, 4'b0111, 0);
    xfer(mk("io_timeout_ch2", 32'h0000_0000, 1, 16, 4'b0100, 15, 0, 16'h0000, 4'h0, 2'b00),
         1, 0, 32'hFFFF_FC20, 32'h0, 0, 4'h0, 4'b1011, 0);
    xfer(mk("unmapped_fc40", 32'h0000_0000, 1, 1, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b00),
         1, 0, 32'hFFFF_FC40, 32'h0, 0, 4'h0, 4'h0, 0);
    xfer(mk("unmapped_top", 32'h0000_0000, 1, 1, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b00),
         0, 1, 32'hFFFF_FFFC, 32'h0, 0, 4'h0, 4'h0, 0);
    xfer(mk("rd_and_wr", 32'h0000_0000, 1, 1, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b00),
         1, 1, 32'h0000_0100, 32'h0, 0, 4'h0, 4'h0, 0);
    xfer(mk("drop_mid_access", 32'h0000_ABCD, 0, 4, 4'b0010, 3, 0, 16'h0009, 4'h4, 2'b00),
         1, 0, 32'hFFFF_FC14, 32'h0000_0009, 3, 4'b0010, 4'h0, 2);

    // Reset asserted during the second ACCESS cycle of a ch2 load.
    cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC20;
    @(posedge clk);
    @(posedge clk); #2;
    chk("rst_mid.io_re_before", 32'(io_re), 32'd1);
    rst_n = 1'b0; cpu_rd = 1'b0;
    #1;
    chk("rst_mid.io_sel", 32'(io_sel), 32'd0);
    chk("rst_mid.io_re", 32'(io_re), 32'd0);
    chk("rst_mid.cpu_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid.cpu_err_after", 32'(cpu_err), 32'd0);
      chk("rst_mid.strb_after", 32'({io_re, io_we, mem_re}), 32'd0);
    end
    @(posedge clk); #1;
    xfer(mk("mem_after_rst", 32'h1234_5678, 0, 0, 4'b0000, 0, 0, 16'h0, 4'h0, 2'b10),
         1, 0, 32'h0000_0004, 32'h0, 0, 4'h0, 4'h0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
